// File: rtl/ray_packet_assembler_pkg.sv
// Shared constants for the ray-generation FIFO consumer: word geometry,
// ray ID width and the slot index of each direction component.
package ray_packet_assembler_pkg;

  localparam int GPU_WORD_W        = 32;
  localparam int RGU_WORDS_PER_RAY = 3;
  localparam int RGU_RAY_ID_SZ     = 16;

  // Position of each direction component within a packet, in pop order.
  localparam int RGU_RAY_WORD_X = 0;
  localparam int RGU_RAY_WORD_Y = 1;
  localparam int RGU_RAY_WORD_Z = 2;

endpackage

// File: rtl/ray_output_slot.sv
// Single-entry output register for an assembled ray packet {id, X, Y, Z}.
// Owns the load / accept / hold behaviour towards the ray-cast core.
module ray_output_slot
  import ray_packet_assembler_pkg::*;
#(
  parameter int WORD_W = GPU_WORD_W,
  parameter int ID_W   = RGU_RAY_ID_SZ
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic              iClear,
  input  logic              iLoad,
  input  logic [ID_W-1:0]   iLoadId,
  input  logic [WORD_W-1:0] iLoadX,
  input  logic [WORD_W-1:0] iLoadY,
  input  logic [WORD_W-1:0] iLoadZ,
  input  logic              iReady,
  output logic              oValid,
  output logic [ID_W-1:0]   oId,
  output logic [WORD_W-1:0] oX,
  output logic [WORD_W-1:0] oY,
  output logic [WORD_W-1:0] oZ
);

  // Handshake: a packet transfers on every edge where oValid && iReady.
  // While oValid && !iReady the payload is frozen; oValid never drops
  // without a transfer except on clear or reset. A load on the accepting
  // edge replaces the packet directly, keeping oValid high with no bubble.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      oValid <= 1'b0;
      oId    <= '0;
      oX     <= '0;
      oY     <= '0;
      oZ     <= '0;
    end else if (iClear) begin
      oValid <= 1'b0;
    end else if (iLoad) begin
      oValid <= 1'b1;
      oId    <= iLoadId;
      oX     <= iLoadX;
      oY     <= iLoadY;
      oZ     <= iLoadZ;
    end else if (oValid && iReady) begin
      oValid <= 1'b0;
    end
  end

endmodule

// File: rtl/ray_packet_assembler.sv
// Pops direction words from the ray-generation FIFO, groups them into
// {X, Y, Z} packets, tags each with a sequential ID and hands them on.
module ray_packet_assembler
  import ray_packet_assembler_pkg::*;
#(
  parameter int WORD_W        = GPU_WORD_W,
  parameter int WORDS_PER_RAY = RGU_WORDS_PER_RAY,
  parameter int ID_W          = RGU_RAY_ID_SZ
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic              iEnable,
  input  logic              iClear,
  input  logic              iFifoEmpty,
  output logic              oFifoPop,
  input  logic [WORD_W-1:0] iFifoData,
  output logic              oRayValid,
  input  logic              iRayReady,
  output logic [WORD_W-1:0] oRayDirX,
  output logic [WORD_W-1:0] oRayDirY,
  output logic [WORD_W-1:0] oRayDirZ,
  output logic [ID_W-1:0]   oRayId,
  output logic              oPartial,
  output logic [ID_W-1:0]   oRayCount
);

  localparam int IDX_W = (WORDS_PER_RAY > 1) ? $clog2(WORDS_PER_RAY) : 1;
  localparam int CNT_W = $clog2(WORDS_PER_RAY + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORDS_PER_RAY - 1);
  localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(WORDS_PER_RAY - 1);
  localparam logic [IDX_W-1:0] SLOT_X    = IDX_W'(RGU_RAY_WORD_X);
  localparam logic [IDX_W-1:0] SLOT_Y    = IDX_W'(RGU_RAY_WORD_Y);

  logic [IDX_W-1:0]  rIdx;
  logic              rPopD;
  logic [WORD_W-1:0] rAsm [2**IDX_W];
  logic [ID_W-1:0]   rIdCnt;
  logic [ID_W-1:0]   rRayCount;

  logic              wAccept;
  logic              wStall;
  logic              wCapture;
  logic              wComplete;
  logic [CNT_W-1:0]  wPopCount;

  assign wAccept   = oRayValid & iRayReady;
  assign wPopCount = CNT_W'(rIdx) + CNT_W'(rPopD);

  // Popping the last word of a packet is only safe if the output slot will
  // be free by the time that word returns; otherwise hold the FIFO.
  assign wStall   = (wPopCount >= STALL_CNT) & oRayValid & ~wAccept;
  assign oFifoPop = iEnable & ~iFifoEmpty & ~iClear & ~wStall & ~iReset;

  assign wCapture  = rPopD & ~iClear;
  assign wComplete = wCapture & (rIdx == LAST_IDX);

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      rIdx      <= '0;
      rPopD     <= 1'b0;
      rIdCnt    <= '0;
      rRayCount <= '0;
    end else if (iClear) begin
      rIdx      <= '0;
      rPopD     <= 1'b0;
      rIdCnt    <= '0;
      rRayCount <= '0;
    end else begin
      rPopD <= oFifoPop;
      if (wCapture) begin
        rIdx <= (rIdx == LAST_IDX) ? '0 : rIdx + 1'b1;
      end
      if (wComplete) begin
        rIdCnt <= rIdCnt + 1'b1;
      end
      if (wAccept) begin
        rRayCount <= rRayCount + 1'b1;
      end
    end
  end

  // Payload-only storage; the last word bypasses it straight into the slot.
  always_ff @(posedge iClock) begin
    if (wCapture) begin
      rAsm[rIdx] <= iFifoData;
    end
  end

  ray_output_slot #(
    .WORD_W (WORD_W),
    .ID_W   (ID_W)
  ) uOutputSlot (
    .iClock  (iClock),
    .iReset  (iReset),
    .iClear  (iClear),
    .iLoad   (wComplete),
    .iLoadId (rIdCnt),
    .iLoadX  (rAsm[SLOT_X]),
    .iLoadY  (rAsm[SLOT_Y]),
    .iLoadZ  (iFifoData),
    .iReady  (iRayReady),
    .oValid  (oRayValid),
    .oId     (oRayId),
    .oX      (oRayDirX),
    .oY      (oRayDirY),
    .oZ      (oRayDirZ)
  );

  assign oPartial  = (rIdx != '0);
  assign oRayCount = rRayCount;

  // The FIFO must never be read while empty.
  assert property (@(posedge iClock) disable iff (iReset)
    oFifoPop |-> !iFifoEmpty);

  // A packet under backpressure must stay put until accepted.
  assert property (@(posedge iClock) disable iff (iReset)
    (oRayValid && !iRayReady && !iClear) |=>
      (oRayValid && $stable(oRayId) && $stable(oRayDirX) &&
       $stable(oRayDirY) && $stable(oRayDirZ)));

endmodule
